sdram_rd_capture: RTL
=====================

Name: sdram_rd_capture

Overview:
- Downstream stage of the SDRAM read command sequencer.
- Snoops the SDRAM command/address bus, tracks each READ through a CAS-latency tag pipeline, and samples iodata on the cycle the data is due.
- Buffers each captured word with its bank/row/column tag in a small show-ahead FIFO.
- Hands words to the consumer over a valid/ready interface.

Parameters:
- CAS_LAT, 3, cycles from a READ command sample to the data sample (legal values 2 or 3).
- DATA_W, 16, SDRAM data width.
- FIFO_DEPTH, 8, capture FIFO entries (power of two).

Ports:
- clk  input  1  system clock; the SDRAM command bus is launched from this clock.
- rst  input  1  asynchronous, active-low reset.
- cke  input  1  SDRAM clock enable as driven to the device.
- control  input  4  {cs_n,ras_n,cas_n,we_n} as driven to the device.
- address  input  13  SDRAM address bus.
- bank  input  2  SDRAM bank address.
- iodata  input  DATA_W  SDRAM DQ bus (read side only).
- rd_data  output  DATA_W  FIFO head data word.
- rd_bank  output  2  bank tag of the head word.
- rd_row  output  13  row tag of the head word.
- rd_col  output  10  column tag of the head word.
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  consumer accepts the head word.
- fifo_count  output  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: a captured word was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - Outputs: rd_data=0, rd_bank=0, rd_row=0, rd_col=0, rd_valid=0, fifo_count=0, overflow=0.
  - Internal: tag pipeline valid bits=0, FIFO pointers=0, open-row register=0.
  - Any READ in flight is discarded.
  - Exit from reset is asynchronous; the first decode happens on the first rising edge with rst=1.
- Command decode happens on each rising edge with cke=1 and cs_n=0:
  - ACTIVE (control=0011): latch open_row<=address, open_bank<=bank.
  - READ (control=0101): inject {valid=1, bank=open_bank, row=open_row, col=address[9:0]} into pipeline stage 1. address[12:10] are ignored.
  - If ACTIVE and READ are back-to-back, the READ uses the row latched by the preceding ACTIVE.
  - All other encodings (NOP 0111, precharge, write, refresh, MRS, deselect) inject valid=0.
- Tag pipeline:
  - CAS_LAT stages; shifts one stage per clk while cke=1.
  - While cke=0, all stages hold, no injection, no capture (clock suspend).
- Capture:
  - A READ sampled at edge N is captured at edge N+CAS_LAT: iodata plus the tag are pushed into the FIFO, given no cke=0 cycles in between.
  - Tags ride with the data, so a later ACTIVE never corrupts an in-flight tag.
- FIFO behaviour:
  - Show-ahead: rd_data and the tags always reflect the head entry.
  - rd_valid is high the cycle after the first push into an empty FIFO (one register stage, no bypass).
  - Pop occurs on an edge with rd_valid=1 and rd_ready=1.
  - rd_ready while empty has no effect.
  - Push and pop on the same edge: both happen and fifo_count is unchanged. This is legal when full.
  - Push when full with no pop: the word is dropped, FIFO contents are unchanged, and overflow<=1.
  - overflow: set has priority over ovf_clr on the same edge; otherwise ovf_clr=1 clears it.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count saturates at FIFO_DEPTH by construction and never exceeds it.
- Throughput: one capture per cycle sustained; a continuous 512-column burst must stream with no gaps when rd_ready=1.
- No handshake back to the sequencer. Backpressure is reported only through fifo_count and overflow.

Test Plan:
- Single read, CL3: ACTIVE row=0x005 bank=0, then READ col=0x010 at edge N; drive iodata=0xA5A5 only at edge N+3 -> one entry {0xA5A5, row 5, col 16}; rd_valid rises after N+3; pop with rd_ready; fifo_count returns to 0.
- Full-row stream: ACTIVE row 1, READs col 0..511 back-to-back, iodata=col, rd_ready=1 -> 512 words in order with rd_col=0..511, rd_row=1, overflow stays 0, fifo_count never above 1.
- Backpressure: rd_ready=0, 10 reads with data 0..9 -> fifo_count=8, overflow=1, contents 0..7. Then drain -> 0..7 in order. Then ovf_clr -> overflow=0.
- Full boundary: FIFO full, rd_ready=1, capture in the same cycle -> no drop, count stays 8, overflow=0.
- Clock suspend and ACTIVE race: READ issued, then cke=0 for 2 cycles, then a new ACTIVE row 7 -> data sampled at N+3+2, tagged with the original row, not row 7.
- Reset mid-burst: rst=0 while 3 READs are in the pipeline and 4 entries are in the FIFO -> all outputs 0 immediately, no stale capture after release; CAS_LAT=2 rerun of the single-read case captures at N+2.

Source files
------------

// File: rtl/sdram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rd_capture
// Brief    : Snoops SDRAM READ commands, captures DQ after CAS latency and
//            queues each word with its bank/row/column tag for a consumer.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rd_capture #(
  parameter int CAS_LAT    = 3,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cke,
  input  logic [3:0]                    control,
  input  logic [12:0]                   address,
  input  logic [1:0]                    bank,
  input  logic [DATA_W-1:0]             iodata,
  output logic [DATA_W-1:0]             rd_data,
  output logic [1:0]                    rd_bank,
  output logic [12:0]                   rd_row,
  output logic [9:0]                    rd_col,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [3:0] c_cmd_active = 4'b0011;
  localparam logic [3:0] c_cmd_read   = 4'b0101;
  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic        vld;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        bank;
    logic [12:0]       row;
    logic [9:0]        col;
  } entry_t;

  logic [12:0]       r_open_row;
  logic [1:0]        r_open_bank;
  tag_t              r_pipe [CAS_LAT];
  entry_t            r_mem  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  logic   w_act;
  logic   w_rd;
  tag_t   w_inject;
  entry_t w_wr_entry;
  logic   w_cap;
  logic   w_full;
  logic   w_valid;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;

  // cs_n is the MSB of control, so the full-nibble compare also requires cs_n=0.
  assign w_act = cke && (control == c_cmd_active);
  assign w_rd  = cke && (control == c_cmd_read);

  always_comb begin
    w_inject = '0;
    if (w_rd) begin
      w_inject.vld  = 1'b1;
      w_inject.bank = r_open_bank;
      w_inject.row  = r_open_row;
      w_inject.col  = address[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_open_row  <= '0;
      r_open_bank <= '0;
    end else if (w_act) begin
      r_open_row  <= address;
      r_open_bank <= bank;
    end
  end

  // Tag pipeline freezes entirely while the device clock is suspended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CAS_LAT; i++) r_pipe[i] <= '0;
    end else if (cke) begin
      r_pipe[0] <= w_inject;
      for (int i = 1; i < CAS_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_cap   = cke && r_pipe[CAS_LAT-1].vld;
  assign w_full  = (r_count == c_full_count);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && rd_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = iodata;
    w_wr_entry.bank = r_pipe[CAS_LAT-1].bank;
    w_wr_entry.row  = r_pipe[CAS_LAT-1].row;
    w_wr_entry.col  = r_pipe[CAS_LAT-1].col;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign rd_data    = r_mem[r_rptr].data;
  assign rd_bank    = r_mem[r_rptr].bank;
  assign rd_row     = r_mem[r_rptr].row;
  assign rd_col     = r_mem[r_rptr].col;
  assign rd_valid   = w_valid;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
